// File: rtl/main_bus_arbiter_if.sv
// Request/grant and snooped bus signals shared between the masters and the round-robin arbiter.
interface main_bus_arbiter_if #(
    parameter int NUM_MASTERS = 2
);
    localparam int OW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    logic [NUM_MASTERS-1:0] req;
    logic [NUM_MASTERS-1:0] gnt;
    logic                   AddrValid;
    logic                   rw;
    logic                   busy;
    logic [OW-1:0]          owner;
    logic                   timeout_err;
    logic                   protocol_err;

    modport slave (
        input  req, AddrValid, rw,
        output gnt, busy, owner, timeout_err, protocol_err
    );

    modport master (
        output req, AddrValid, rw,
        input  gnt, busy, owner, timeout_err, protocol_err
    );
endinterface

// File: rtl/main_bus_arbiter.sv
// Round-robin arbiter for the main bus: grants one master, follows its burst by snooping
// AddrValid/rw, and releases on burst end, grant timeout or request drop.
module main_bus_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int BURST       = 4,
    parameter int GNT_TIMEOUT = 8
) (
    input  logic              clk,
    input  logic              resetH,
    main_bus_arbiter_if.slave bus
);
    localparam int OW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int WW = $clog2(GNT_TIMEOUT + 1);
    localparam int DW = $clog2(BURST + 1);
    localparam logic [OW-1:0] LAST_IDX = OW'(NUM_MASTERS - 1);

    typedef enum logic [1:0] {IDLE, GRANT, XFER, TURN} stateT;

    stateT                  state, stateNext;
    logic [OW-1:0]          owner, ownerNext;
    logic [OW-1:0]          rrPtr, rrPtrNext;
    logic [OW-1:0]          ownerInc;
    logic [OW-1:0]          winner;
    logic                   anyReq;
    logic                   rwLatch, rwLatchNext;
    logic [WW-1:0]          waitCnt, waitCntNext;
    logic [DW-1:0]          dataCnt, dataCntNext;
    logic [NUM_MASTERS-1:0] gnt, gntNext;
    logic                   timeoutErr, timeoutErrNext;
    logic                   protocolErr, protocolErrNext;

    assign ownerInc = (owner == LAST_IDX) ? '0 : owner + OW'(1);

    // First requester at or after rrPtr, wrapping past the highest index.
    always_comb begin : pickWinner
        int unsigned idx;
        logic        found;
        anyReq = |bus.req;
        winner = rrPtr;
        found  = 1'b0;
        idx    = 0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            idx = int'(rrPtr) + i;
            if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
            if (!found && bus.req[idx]) begin
                found  = 1'b1;
                winner = OW'(idx);
            end
        end
    end

    always_comb begin
        stateNext       = state;
        ownerNext       = owner;
        rrPtrNext       = rrPtr;
        rwLatchNext     = rwLatch;
        timeoutErrNext  = 1'b0;
        protocolErrNext = bus.AddrValid && (state != GRANT);
        gntNext         = '0;

        case (state)
            IDLE: begin
                if (anyReq) begin
                    stateNext = GRANT;
                    ownerNext = winner;
                end
            end
            GRANT: begin
                // AddrValid takes precedence over a simultaneous request drop.
                if (bus.AddrValid) begin
                    stateNext   = XFER;
                    rwLatchNext = bus.rw;
                end else if (!bus.req[owner]) begin
                    stateNext = IDLE;
                    rrPtrNext = ownerInc;
                end else if (waitCnt == WW'(GNT_TIMEOUT - 1)) begin
                    stateNext      = IDLE;
                    rrPtrNext      = ownerInc;
                    timeoutErrNext = 1'b1;
                end
            end
            XFER: begin
                if (dataCnt == DW'(BURST - 1)) begin
                    stateNext = rwLatch ? TURN : IDLE;
                    rrPtrNext = ownerInc;
                end
            end
            TURN:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase

        if (stateNext == GRANT || stateNext == XFER) gntNext[ownerNext] = 1'b1;

        waitCntNext = '0;
        dataCntNext = '0;
        if (stateNext == state) begin
            waitCntNext = (state == GRANT) ? waitCnt + WW'(1) : waitCnt;
            dataCntNext = (state == XFER)  ? dataCnt + DW'(1) : dataCnt;
        end
    end

    always_ff @(posedge clk or posedge resetH) begin
        if (resetH) begin
            state       <= IDLE;
            owner       <= '0;
            rrPtr       <= '0;
            rwLatch     <= 1'b0;
            waitCnt     <= '0;
            dataCnt     <= '0;
            gnt         <= '0;
            timeoutErr  <= 1'b0;
            protocolErr <= 1'b0;
        end else begin
            state       <= stateNext;
            owner       <= ownerNext;
            rrPtr       <= rrPtrNext;
            rwLatch     <= rwLatchNext;
            waitCnt     <= waitCntNext;
            dataCnt     <= dataCntNext;
            gnt         <= gntNext;
            timeoutErr  <= timeoutErrNext;
            protocolErr <= protocolErrNext;
        end
    end

    assign bus.gnt          = gnt;
    assign bus.busy         = (state != IDLE);
    assign bus.owner        = owner;
    assign bus.timeout_err  = timeoutErr;
    assign bus.protocol_err = protocolErr;
endmodule

// File: tb/tb_main_bus_arbiter.sv
// Bench for main_bus_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model of the grant/burst/turnaround rules.
module tb_main_bus_arbiter;
    localparam int N     = 2;
    localparam int BURST = 4;
    localparam int TO    = 8;

    logic clk = 1'b0;
    logic resetH = 1'b1;
    always #5 clk = ~clk;

    main_bus_arbiter_if #(.NUM_MASTERS(N)) bus();

    main_bus_arbiter #(
        .NUM_MASTERS(N),
        .BURST(BURST),
        .GNT_TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .resetH(resetH),
        .bus(bus)
    );

    int tests = 0;
    int failures = 0;

    // Model: who holds the bus, how many data beats remain, how long the holder has waited
    // for its address, and how many forced dead cycles remain after a read.
    int mOwner, mLeft, mAge, mHold, mPtr, avDelay;
    bit mGranted, mRead, eTo, eProto;
    bit autoAv, randomMode;
    logic [N-1:0] rdMask;

    function automatic void modelReset();
        mOwner = 0; mLeft = 0; mAge = 0; mHold = 0; mPtr = 0;
        mGranted = 0; mRead = 0; eTo = 0; eProto = 0;
    endfunction

    function automatic void modelStep();
        bit waiting;
        bit found;
        waiting = mGranted && (mLeft == 0);
        eTo = 0;
        eProto = bus.AddrValid && !waiting;
        if (waiting) begin
            if (bus.AddrValid) begin
                mLeft = BURST;
                mRead = bus.rw;
            end else if (!bus.req[mOwner]) begin
                mGranted = 0;
                mPtr = (mOwner + 1) % N;
            end else begin
                mAge++;
                if (mAge == TO) begin
                    mGranted = 0;
                    mPtr = (mOwner + 1) % N;
                    eTo = 1;
                end
            end
        end else if (mGranted) begin
            mLeft--;
            if (mLeft == 0) begin
                mGranted = 0;
                mPtr = (mOwner + 1) % N;
                mHold = mRead ? 1 : 0;
            end
        end else if (mHold > 0) begin
            mHold--;
        end else if (bus.req != '0) begin
            found = 0;
            for (int k = 0; k < N; k++) begin
                if (!found && bus.req[(mPtr + k) % N]) begin
                    found = 1;
                    mOwner = (mPtr + k) % N;
                end
            end
            mGranted = 1;
            mAge = 0;
            avDelay = randomMode ? int'($urandom_range(0, TO + 1)) : 0;
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic checkAll();
        logic [N-1:0] eg;
        eg = mGranted ? (N'(1) << mOwner) : '0;
        chk("gnt", 32'(bus.gnt), 32'(eg));
        chk("busy", 32'(bus.busy), 32'(mGranted || (mHold > 0)));
        chk("owner", 32'(bus.owner), 32'(mOwner));
        chk("timeout_err", 32'(bus.timeout_err), 32'(eTo));
        chk("protocol_err", 32'(bus.protocol_err), 32'(eProto));
    endtask

    task automatic driveNext();
        bit waiting;
        waiting = mGranted && (mLeft == 0);
        if (autoAv && waiting && mAge >= avDelay) begin
            bus.AddrValid = 1'b1;
            bus.rw = randomMode ? 1'($urandom % 2) : rdMask[mOwner];
        end else begin
            bus.AddrValid = randomMode && ($urandom % 20 == 0);
            bus.rw = randomMode ? 1'($urandom % 2) : 1'b0;
        end
        if (randomMode)
            for (int i = 0; i < N; i++)
                if ($urandom % 8 == 0) bus.req[i] = ~bus.req[i];
    endtask

    task automatic cycle();
        @(posedge clk);
        modelStep();
        #1;
        checkAll();
        driveNext();
    endtask

    task automatic doReset();
        resetH = 1'b1;
        bus.req = '0;
        bus.AddrValid = 1'b0;
        bus.rw = 1'b0;
        #2;
        modelReset();
        checkAll();
        @(posedge clk);
        #1;
        resetH = 1'b0;
    endtask

    initial begin
        logic [N-1:0] grantSeq[$];
        int gaps[$];
        logic [N-1:0] prevG;
        int idleCnt;
        logic [N-1:0] exp3[10];

        bus.req = '0; bus.AddrValid = 1'b0; bus.rw = 1'b0;
        autoAv = 0; randomMode = 0; rdMask = '0; avDelay = 0;
        modelReset();

        // 1: single write burst by master 0
        doReset();
        chk("reset_gnt", 32'(bus.gnt), 32'h0);
        bus.req = 2'b01;
        cycle();
        chk("t1_gnt", 32'(bus.gnt), 32'h1);
        chk("t1_busy", 32'(bus.busy), 32'h1);
        bus.AddrValid = 1'b1; bus.rw = 1'b0; bus.req = 2'b00;
        cycle();
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("t1_held", 32'(bus.gnt), 32'h1);
        end
        cycle();
        chk("t1_release", 32'(bus.gnt), 32'h0);
        chk("t1_idle", 32'(bus.busy), 32'h0);

        // 2: both masters write continuously; grants alternate with one idle cycle
        doReset();
        autoAv = 1; rdMask = 2'b00;
        bus.req = 2'b11;
        prevG = '0; idleCnt = 0;
        for (int k = 0; k < 22; k++) begin
            cycle();
            if (bus.gnt != '0 && prevG == '0) begin
                if (grantSeq.size() > 0) gaps.push_back(idleCnt);
                grantSeq.push_back(bus.gnt);
                idleCnt = 0;
            end
            if (bus.gnt == '0) idleCnt++;
            prevG = bus.gnt;
        end
        chk("t2_grants", 32'(grantSeq.size() >= 4), 32'h1);
        if (grantSeq.size() >= 4) begin
            chk("t2_g0", 32'(grantSeq[0]), 32'h1);
            chk("t2_g1", 32'(grantSeq[1]), 32'h2);
            chk("t2_g2", 32'(grantSeq[2]), 32'h1);
            chk("t2_g3", 32'(grantSeq[3]), 32'h2);
        end
        foreach (gaps[i]) chk("t2_gap", 32'(gaps[i]), 32'h1);

        // 3: read burst by master 1, turnaround then idle before regrant
        doReset();
        autoAv = 1; rdMask = 2'b10;
        bus.req = 2'b10;
        exp3 = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00, 2'b10, 2'b10, 2'b10};
        for (int k = 0; k < 10; k++) begin
            cycle();
            chk("t3_gnt", 32'(bus.gnt), 32'(exp3[k]));
            if (k == 5) chk("t3_turn_busy", 32'(bus.busy), 32'h1);
            if (k == 6) chk("t3_idle_busy", 32'(bus.busy), 32'h0);
        end

        // 4: master 0 never issues an address; grant times out and passes to master 1
        doReset();
        autoAv = 0;
        bus.req = 2'b11;
        for (int k = 0; k < TO; k++) begin
            cycle();
            chk("t4_wait", 32'(bus.gnt), 32'h1);
        end
        cycle();
        chk("t4_gnt_drop", 32'(bus.gnt), 32'h0);
        chk("t4_timeout", 32'(bus.timeout_err), 32'h1);
        cycle();
        chk("t4_next", 32'(bus.gnt), 32'h2);
        chk("t4_pulse", 32'(bus.timeout_err), 32'h0);

        // 5: stray AddrValid while idle
        doReset();
        bus.AddrValid = 1'b1;
        cycle();
        chk("t5_perr", 32'(bus.protocol_err), 32'h1);
        chk("t5_gnt", 32'(bus.gnt), 32'h0);
        cycle();
        chk("t5_perr_pulse", 32'(bus.protocol_err), 32'h0);
        chk("t5_busy", 32'(bus.busy), 32'h0);

        // 6: reset during second data cycle
        doReset();
        autoAv = 1; rdMask = 2'b00;
        bus.req = 2'b01;
        cycle();
        cycle();
        cycle();
        #2;
        resetH = 1'b1;
        #1;
        chk("t6_async", 32'(bus.gnt), 32'h0);
        doReset();
        bus.req = 2'b10;
        cycle();
        chk("t6_regrant", 32'(bus.gnt), 32'h2);

        // Randomized traffic against the model
        doReset();
        autoAv = 1; randomMode = 1;
        bus.req = N'($urandom);
        for (int k = 0; k < 3000; k++) cycle();

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end
endmodule
